ad1_sample_avg: RTL and testbench

AD1_SAMPLE_AVG -- requirements
Module: ad1_sample_avg

---
 rtl/ad1_sample_avg.sv | 133 +++++++++++++
 tb/tb_ad1_sample_avg.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ad1_sample_avg.sv
// Two-channel boxcar averager for AD1 poller words: N = 2^LOG2_N samples per output.
// Optional threshold alarms are built only when AD1_AVG_ALARM_EN is defined.
module ad1_sample_avg #(
    parameter int unsigned LOG2_N   = 4,
    parameter logic [11:0] ALARM_HI = 12'd3000,
    parameter logic [11:0] ALARM_LO = 12'd2900
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din0,
    input  logic [15:0] din1,
    input  logic        din_valid,
    input  logic        clr,
    output logic [11:0] avg0,
    output logic [11:0] avg1,
    output logic        avg_valid,
    output logic        alarm0,
    output logic        alarm1
);

    localparam int unsigned ACC_W = 12 + LOG2_N;
    // Counter is never read when LOG2_N = 0; keep it at one bit so it stays legal.
    localparam int unsigned CNT_W = (LOG2_N == 0) ? 1 : LOG2_N;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

    typedef enum logic {
        ACC,
        LAST
    } state_t;

    state_t             state, state_nxt;
    logic               valid_d;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ACC_W-1:0]   acc0, acc1, acc0_nxt, acc1_nxt;
    logic [ACC_W-1:0]   sum0, sum1;
    logic [11:0]        avg0_new, avg1_new;
    logic               accept;
    logic               close;

    // The poller's status nibble is not part of the sample.
    logic unused_din_hi;
    assign unused_din_hi = ^{din0[15:12], din1[15:12]};

    assign accept   = din_valid & ~valid_d;
    assign sum0     = acc0 + ACC_W'(din0[11:0]);
    assign sum1     = acc1 + ACC_W'(din1[11:0]);
    assign avg0_new = 12'(sum0 >> LOG2_N);
    assign avg1_new = 12'(sum1 >> LOG2_N);

    // NOTE: every output of this always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc0_nxt  = acc0;
        acc1_nxt  = acc1;
        close     = 1'b0;
        if (clr) begin
            state_nxt = ACC;
            cnt_nxt   = '0;
            acc0_nxt  = '0;
            acc1_nxt  = '0;
        end else if (accept) begin
            case (state)
                ACC: begin
                    if (LOG2_N == 0) begin
                        close = 1'b1;
                    end else begin
                        acc0_nxt = sum0;
                        acc1_nxt = sum1;
                        cnt_nxt  = cnt + CNT_W'(1);
                        if (cnt == CNT_LAST - CNT_W'(1)) begin
                            state_nxt = LAST;
                        end
                    end
                end
                LAST: begin
                    close     = 1'b1;
                    state_nxt = ACC;
                    cnt_nxt   = '0;
                    acc0_nxt  = '0;
                    acc1_nxt  = '0;
                end
                default: state_nxt = ACC;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ACC;
            cnt       <= '0;
            acc0      <= '0;
            acc1      <= '0;
            valid_d   <= 1'b0;
            avg0      <= '0;
            avg1      <= '0;
            avg_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc0      <= acc0_nxt;
            acc1      <= acc1_nxt;
            valid_d   <= din_valid;
            avg_valid <= close;
            if (close) begin
                avg0 <= avg0_new;
                avg1 <= avg1_new;
            end
        end
    end

`ifdef AD1_AVG_ALARM_EN
    // Hysteresis: set at or above HI, clear below LO, hold in between.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm0 <= 1'b0;
            alarm1 <= 1'b0;
        end else if (close) begin
            if (avg0_new >= ALARM_HI)     alarm0 <= 1'b1;
            else if (avg0_new < ALARM_LO) alarm0 <= 1'b0;
            if (avg1_new >= ALARM_HI)     alarm1 <= 1'b1;
            else if (avg1_new < ALARM_LO) alarm1 <= 1'b0;
        end
    end
`else
    logic [23:0] unused_thresholds;
    assign unused_thresholds = {ALARM_HI, ALARM_LO};
    assign alarm0 = 1'b0;
    assign alarm1 = 1'b0;
`endif

endmodule

// File: tb/tb_ad1_sample_avg.sv
// Directed bench for ad1_sample_avg: a LOG2_N=4 instance and a LOG2_N=0 pass-through instance.
module tb_ad1_sample_avg;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din0, din1;
    logic        din_valid, clr;
    logic [11:0] avg0, avg1, z_avg0, z_avg1;
    logic        avg_valid, alarm0, alarm1;
    logic        z_valid, z_alarm0, z_alarm1;

    always #5 clk = ~clk;

    ad1_sample_avg #(.LOG2_N(4)) dut (
        .clk(clk), .reset(reset), .din0(din0), .din1(din1), .din_valid(din_valid), .clr(clr),
        .avg0(avg0), .avg1(avg1), .avg_valid(avg_valid), .alarm0(alarm0), .alarm1(alarm1)
    );

    ad1_sample_avg #(.LOG2_N(0)) dut0 (
        .clk(clk), .reset(reset), .din0(din0), .din1(din1), .din_valid(din_valid), .clr(clr),
        .avg0(z_avg0), .avg1(z_avg1), .avg_valid(z_valid), .alarm0(z_alarm0), .alarm1(z_alarm1)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    int   nv     = 0;
    logic exp_al0 = 1'b0;
    logic exp_al1 = 1'b0;

    // avg_valid is one cycle wide, so the pre-edge value is seen at exactly one posedge.
    always @(posedge clk) if (avg_valid) nv++;

    typedef struct {
        string       name;
        logic [15:0] d0a, d0b, d1;
        logic [11:0] e0, e1;
        int          hi, lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic next_alarm(input logic cur, input logic [11:0] a);
`ifdef AD1_AVG_ALARM_EN
        if (a >= 12'd3000) return 1'b1;
        if (a < 12'd2900)  return 1'b0;
        return cur;
`else
        return 1'b0;
`endif
    endfunction

    // One din_valid pulse; the pass-through instance must answer one clk after every rising edge.
    task automatic pulse(input logic [15:0] d0, input logic [15:0] d1, input int hi, input int lo,
                         input bit last, input logic [11:0] e0, input logic [11:0] e1);
        @(negedge clk);
        din0 = d0; din1 = d1; din_valid = 1'b1;
        @(negedge clk);
        check("pass-through valid", z_valid, 1'b1);
        check("pass-through avg0", z_avg0, d0[11:0]);
        check("pass-through avg1", z_avg1, d1[11:0]);
        if (last) begin
            exp_al0 = next_alarm(exp_al0, e0);
            exp_al1 = next_alarm(exp_al1, e1);
            check("avg_valid at T+1", avg_valid, 1'b1);
            check("avg0", avg0, e0);
            check("avg1", avg1, e1);
            check("alarm0", alarm0, exp_al0);
            check("alarm1", alarm1, exp_al1);
        end
        @(negedge clk);
        if (last) check("avg_valid one cycle", avg_valid, 1'b0);
        check("no re-accept while held", z_valid, 1'b0);
        repeat (hi - 2) @(negedge clk);
        din_valid = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic window(input vec_t v);
        int base;
        base = nv;
        for (int i = 0; i < 15; i++)
            pulse((i % 2) ? v.d0b : v.d0a, v.d1, v.hi, v.lo, 1'b0, '0, '0);
        check({v.name, " no early avg_valid"}, nv - base, 0);
        pulse(v.d0b, v.d1, v.hi, v.lo, 1'b1, v.e0, v.e1);
        check({v.name, " one avg_valid"}, nv - base, 1);
        check({v.name, " avg0 held"}, avg0, v.e0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " avg0"}, avg0, 12'h000);
        check({name, " avg1"}, avg1, 12'h000);
        check({name, " avg_valid"}, avg_valid, 1'b0);
        check({name, " alarm0"}, alarm0, 1'b0);
        check({name, " alarm1"}, alarm1, 1'b0);
        check({name, " pass-through avg0"}, z_avg0, 12'h000);
        check({name, " pass-through valid"}, z_valid, 1'b0);
    endtask

    initial begin
        vec_t v;
        int   base;
        vecs[0] = '{"mid-scale",  16'h0800, 16'h0800, 16'h0400, 12'h800, 12'h400, 100, 300};
        vecs[1] = '{"upper nib",  16'hF123, 16'hF123, 16'h0FFF, 12'h123, 12'hFFF, 3, 3};
        vecs[2] = '{"full scale", 16'h0FFF, 16'h0FFF, 16'h0000, 12'hFFF, 12'h000, 3, 3};
        vecs[3] = '{"truncate",   16'h0000, 16'h0001, 16'hA005, 12'h000, 12'h005, 3, 3};
        vecs[4] = '{"mixed",      16'h0010, 16'h0020, 16'h0FFE, 12'h018, 12'hFFE, 3, 3};
        vecs[5] = '{"alarm set",  16'h0BB9, 16'h0BB7, 16'h0B53, 12'd3000, 12'd2899, 3, 3};
        vecs[6] = '{"alarm hold", 16'h0B86, 16'h0B86, 16'h0BBD, 12'd2950, 12'd3005, 3, 3};
        vecs[7] = '{"alarm clr",  16'h0B53, 16'h0B53, 16'h0B86, 12'd2899, 12'd2950, 3, 3};
        vecs[8] = '{"low",        16'h0003, 16'h0003, 16'h0007, 12'h003, 12'h007, 3, 3};

        reset = 1'b0; din_valid = 1'b0; clr = 1'b0; din0 = '0; din1 = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) window(vecs[i]);

        // clr mid-window: the five earlier samples must be forgotten.
        for (int i = 0; i < 5; i++) pulse(16'h0111, 16'h0111, 3, 3, 1'b0, '0, '0);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        check("clr keeps avg0", avg0, 12'h003);
        check("clr suppresses valid", avg_valid, 1'b0);
        v = '{"after clr", 16'h0222, 16'h0222, 16'h0333, 12'h222, 12'h333, 3, 3};
        window(v);

        // clr on a rising edge: sample dropped, and the held level is not re-accepted after clr.
        for (int i = 0; i < 7; i++) pulse(16'h0333, 16'h0333, 3, 3, 1'b0, '0, '0);
        base = nv;
        @(negedge clk);
        din0 = 16'h0FFF; din1 = 16'h0FFF; din_valid = 1'b1; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr+edge no valid", avg_valid, 1'b0);
        check("clr+edge pass-through no valid", z_valid, 1'b0);
        check("clr+edge keeps pass-through avg", z_avg0, 12'h333);
        repeat (3) @(negedge clk);
        check("held level after clr not accepted", z_valid, 1'b0);
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("clr+edge no avg_valid", nv - base, 0);
        v = '{"after clr edge", 16'h0444, 16'h0444, 16'h0555, 12'h444, 12'h555, 3, 3};
        window(v);

        // Reset mid-window discards the partial sums.
        for (int i = 0; i < 10; i++) pulse(16'h0555, 16'h0555, 3, 3, 1'b0, '0, '0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check_all_zero("mid reset");
        exp_al0 = 1'b0; exp_al1 = 1'b0;
        reset = 1'b1;
        v = '{"after reset", 16'h0100, 16'h0100, 16'h0101, 12'h100, 12'h101, 3, 3};
        window(v);

        // din_valid already high at reset release counts as the first sample.
        @(negedge clk);
        reset = 1'b0; din0 = 16'h0200; din1 = 16'h0201; din_valid = 1'b1;
        repeat (2) @(negedge clk);
        exp_al0 = 1'b0; exp_al1 = 1'b0;
        reset = 1'b1;
        base = nv;
        @(negedge clk);
        check("high at release pass-through valid", z_valid, 1'b1);
        check("high at release pass-through avg0", z_avg0, 12'h200);
        repeat (2) @(negedge clk);
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 14; i++) pulse(16'h0200, 16'h0201, 3, 3, 1'b0, '0, '0);
        check("high at release no early valid", nv - base, 0);
        pulse(16'h0200, 16'h0201, 3, 3, 1'b1, 12'h200, 12'h201);
        check("high at release one valid", nv - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
